// File: rtl/game_over_seq_pkg.sv
// Shared definitions for the game-over sprite sequencer: screen geometry,
// FSM state encoding and a small constant helper.
package game_over_seq_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } go_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_over_seq_go_frame_timer.sv
// Frame-tick counter that wraps after LIMIT ticks; wrap pulses on the tick
// that completes a period, clear holds the count at zero.
module go_frame_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign wrap = tick & ~clear & (cnt == LAST);

  // Tick counter with clear priority and wrap back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (clear) begin
      cnt <= {W{1'b0}};
    end else if (tick) begin
      if (cnt == LAST) begin
        cnt <= {W{1'b0}};
      end else begin
        cnt <= cnt + W'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/game_over_seq.sv
// Game-over sprite sequencer: slide down to centre, hold, wait for restart.
// Optional feature macro GO_BLINK_EN: blink the sprite while waiting.
module game_over_seq
  import game_over_seq_pkg::*;
#(
  parameter int IMG_W        = 344,
  parameter int IMG_H        = 90,
  parameter int SLIDE_STEP   = 4,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        game_over_in,
  input  logic        restart_btn,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic        sprite_en,
  output logic        restart_req,
  output logic        busy
);

  localparam int          CNT_W = $clog2(max_int(HOLD_FRAMES, BLINK_FRAMES)) + 1;
  localparam logic [10:0] XC    = 11'((H_ACTIVE - IMG_W) / 2);
  localparam logic [10:0] YT    = 11'((V_ACTIVE - IMG_H) / 2);
  localparam logic [10:0] STEP  = 11'(SLIDE_STEP);
  localparam logic [10:0] W11   = 11'(IMG_W);
  localparam logic [10:0] H11   = 11'(IMG_H);

  go_state_e   state;
  go_state_e   state_next;
  logic        go_q;
  logic        btn_q;
  logic        go_rise;
  logic        btn_rise;
  logic        hold_wrap;
  logic [10:0] y0_next;
  logic [10:0] y_step;
  logic        restart_next;
  logic        en_next;

  assign go_rise  = game_over_in & ~go_q;
  assign btn_rise = restart_btn & ~btn_q;
  assign y_step   = y0 + STEP;

  go_frame_timer #(
    .W     (CNT_W),
    .LIMIT (HOLD_FRAMES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != HOLD),
    .tick  (frame_tick),
    .wrap  (hold_wrap)
  );

  // Next-state, next-position and restart pulse; a dropped game_over_in wins
  always_comb begin
    state_next   = state;
    y0_next      = y0;
    restart_next = 1'b0;
    case (state)
      IDLE: begin
        if (go_rise) begin
          y0_next    = 11'd0;
          state_next = SLIDE;
        end else begin
          state_next = IDLE;
        end
      end
      SLIDE: begin
        if (!game_over_in) begin
          state_next = IDLE;
        end else if (frame_tick) begin
          if (y_step >= YT) begin
            y0_next    = YT;
            state_next = HOLD;
          end else begin
            y0_next    = y_step;
          end
        end else begin
          state_next = SLIDE;
        end
      end
      HOLD: begin
        if (!game_over_in) begin
          state_next = IDLE;
        end else if (hold_wrap) begin
          state_next = WAIT;
        end else begin
          state_next = HOLD;
        end
      end
      WAIT: begin
        if (!game_over_in) begin
          state_next = IDLE;
        end else if (btn_rise) begin
          restart_next = 1'b1;
          state_next   = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef GO_BLINK_EN
  logic blink_wrap;
  logic blink_on;
  logic blink_next;

  go_frame_timer #(
    .W     (CNT_W),
    .LIMIT (BLINK_FRAMES)
  ) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != WAIT),
    .tick  (frame_tick),
    .wrap  (blink_wrap)
  );

  // Blink phase restarts visible on every WAIT entry
  always_comb begin
    if (state != WAIT) begin
      blink_next = 1'b1;
    end else if (blink_wrap) begin
      blink_next = ~blink_on;
    end else begin
      blink_next = blink_on;
    end
    if (state_next == WAIT) begin
      en_next = blink_next;
    end else begin
      en_next = (state_next != IDLE);
    end
  end

  // Blink phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_on <= 1'b1;
    end else begin
      blink_on <= blink_next;
    end
  end
`else
  // Sprite visible in every active state
  always_comb begin
    en_next = (state_next != IDLE);
  end
`endif

  // State, edge detectors and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      go_q        <= 1'b0;
      btn_q       <= 1'b0;
      x0          <= XC;
      y0          <= 11'd0;
      x1          <= XC + W11;
      y1          <= H11;
      sprite_en   <= 1'b0;
      restart_req <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      go_q        <= game_over_in;
      btn_q       <= restart_btn;
      x0          <= XC;
      y0          <= y0_next;
      x1          <= XC + W11;
      y1          <= y0_next + H11;
      sprite_en   <= en_next;
      restart_req <= restart_next;
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_game_over_seq.sv
// Self-checking bench for game_over_seq: vector table, directed corner
// sequences and random stimulus against a frame-counting reference model.
module tb_game_over_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        game_over_in;
  logic        restart_btn;
  logic [10:0] x0, y0, x1, y1;
  logic        sprite_en, restart_req, busy;

  always #5 clk = ~clk;

  game_over_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .game_over_in (game_over_in),
    .restart_btn  (restart_btn),
    .x0           (x0),
    .y0           (y0),
    .x1           (x1),
    .y1           (y1),
    .sprite_en    (sprite_en),
    .restart_req  (restart_req),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 sliding, 2 holding, 3 waiting
  int   m_phase, m_k, m_y, m_h, m_w;
  logic m_go_prev, m_btn_prev, m_req;

  function automatic void model_reset();
    m_phase = 0; m_k = 0; m_y = 0; m_h = 0; m_w = 0;
    m_go_prev = 1'b0; m_btn_prev = 1'b0; m_req = 1'b0;
  endfunction

  function automatic void model_step(input logic go, input logic tick, input logic btn);
    logic rise, brise;
    rise  = go & ~m_go_prev;
    brise = btn & ~m_btn_prev;
    m_req = 1'b0;
    case (m_phase)
      0: if (rise) begin m_phase = 1; m_k = 0; m_y = 0; end
      1: if (!go) m_phase = 0;
         else if (tick) begin
           m_k = m_k + 1;
           m_y = (4 * m_k >= 195) ? 195 : 4 * m_k;
           if (m_y == 195) begin m_phase = 2; m_h = 0; end
         end
      2: if (!go) m_phase = 0;
         else if (tick) begin
           m_h = m_h + 1;
           if (m_h == 120) begin m_phase = 3; m_w = 0; end
         end
      3: if (!go) m_phase = 0;
         else if (brise) begin m_req = 1'b1; m_phase = 0; end
         else if (tick) m_w = m_w + 1;
      default: m_phase = 0;
    endcase
    m_go_prev  = go;
    m_btn_prev = btn;
  endfunction

  function automatic logic model_en();
    if (m_phase == 0) return 1'b0;
`ifdef GO_BLINK_EN
    if (m_phase == 3) return ((m_w / 15) % 2) == 0;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/x0"}, 32'(x0), 32'd148);
    check({tag, "/x1"}, 32'(x1), 32'd492);
    check({tag, "/y0"}, 32'(y0), 32'(m_y));
    check({tag, "/y1"}, 32'(y1), 32'(m_y + 90));
    check({tag, "/en"}, 32'(sprite_en), 32'(model_en()));
    check({tag, "/req"}, 32'(restart_req), 32'(m_req));
    check({tag, "/busy"}, 32'(busy), 32'(m_phase != 0));
  endtask

  task automatic cyc(input logic go, input logic tick, input logic btn);
    game_over_in = go;
    frame_tick   = tick;
    restart_btn  = btn;
    model_step(go, tick, btn);
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  typedef struct {
    logic        go;
    logic        tick;
    logic        btn;
    logic [10:0] y0;
    logic        en;
    logic        req;
    logic        busy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic go_r, btn_r;
    logic exp_en;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 11'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 11'd4,  1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 11'd8,  1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 11'd8,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 11'd12, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 11'd12, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 11'd12, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 11'd4,  1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; frame_tick = 1'b0; game_over_in = 1'b0; restart_btn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    check("reset/y1", 32'(y1), 32'd90);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].go, vecs[i].tick, vecs[i].btn);
      check($sformatf("vec%0d/y0", i), 32'(y0), 32'(vecs[i].y0));
      check($sformatf("vec%0d/y1", i), 32'(y1), 32'(vecs[i].y0) + 32'd90);
      check($sformatf("vec%0d/en", i), 32'(sprite_en), 32'(vecs[i].en));
      check($sformatf("vec%0d/req", i), 32'(restart_req), 32'(vecs[i].req));
      check($sformatf("vec%0d/busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Full slide to centre, hold, restart
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("slide/start_y0", 32'(y0), 32'd0);
    for (int i = 1; i <= 49; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i < 49) check($sformatf("slide/y0_%0d", i), 32'(y0), 32'(4 * i));
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("slide/clamp_y0", 32'(y0), 32'd195);
    check("slide/clamp_y1", 32'(y1), 32'd285);
    for (int i = 1; i <= 120; i++) begin
      cyc(1'b1, 1'b1, (i == 60) ? 1'b1 : 1'b0);
      check($sformatf("hold/req_%0d", i), 32'(restart_req), 32'd0);
      check($sformatf("hold/busy_%0d", i), 32'(busy), 32'd1);
    end
    check("wait/entry_en", 32'(sprite_en), 32'd1);
    for (int i = 1; i <= 15; i++) cyc(1'b1, 1'b1, 1'b0);
`ifdef GO_BLINK_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    check("wait/en_after15", 32'(sprite_en), 32'(exp_en));
    cyc(1'b1, 1'b0, 1'b1);
    check("restart/req", 32'(restart_req), 32'd1);
    check("restart/busy", 32'(busy), 32'd0);
    check("restart/en", 32'(sprite_en), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    check("restart/req_once", 32'(restart_req), 32'd0);

    // Level held high after restart must not retrigger
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      check("retrig/held_busy", 32'(busy), 32'd0);
      check("retrig/held_en", 32'(sprite_en), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("retrig/busy", 32'(busy), 32'd1);
    check("retrig/y0", 32'(y0), 32'd0);

    // Abort mid-slide coincident with a frame tick
    for (int i = 0; i < 25; i++) cyc(1'b1, 1'b1, 1'b0);
    check("abort/pre_y0", 32'(y0), 32'd100);
    cyc(1'b0, 1'b1, 1'b0);
    check("abort/y0", 32'(y0), 32'd100);
    check("abort/en", 32'(sprite_en), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/req", 32'(restart_req), 32'd0);

    // Asynchronous reset mid-slide
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    check("mreset/pre_y0", 32'(y0), 32'd40);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("mreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("mreset/rise_on_release", 32'(busy), 32'd1);

    // Random stimulus against the model
    go_r = 1'b1; btn_r = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (go_r) go_r = ($urandom_range(0, 999) != 0);
      else      go_r = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) btn_r = ~btn_r;
      cyc(go_r, ($urandom_range(0, 2) == 0), btn_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
